// File: rtl/mips_dmem_responder.sv
// Fixed-latency word data memory for the MIPS core's load/store port; one request in flight at a time.
// Optional build macro DMEM_ALIGN_CHECK_EN adds the misaligned port and suppresses misaligned accesses.
module mips_dmem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mips_dmem_responder: LATENCY must be >= 1");
  end
  if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("mips_dmem_responder: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic               mis_q, mis_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               mis_out_q, mis_out_d;
  logic               enter_resp;
  logic               mem_we;
  logic               addr_mis;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_mis = |addr[1:0];
  logic unused_addr;
  assign unused_addr = ^addr[31:IDX_W+2];
`else
  assign addr_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0], mis_out_q};
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    mis_d      = mis_q;
    rd_data_d  = rd_data_q;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_read_en || mem_write_en) begin
          idx_d   = addr[IDX_W+1:2];
          wdata_d = wr_data;
          write_d = mem_write_en;
          mis_d   = addr_mis;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The *_d transaction fields already select live inputs on a same-edge accept (LATENCY==1).
    if (enter_resp) begin
      rd_data_d = mis_d ? 32'h0 : mem[idx_d];
      mem_we    = write_d && !mis_d && !rst;
    end

    ready_d   = (state_d == S_RESP);
    busy_d    = (state_d != S_IDLE);
    mis_out_d = (state_d == S_RESP) && mis_d;
  end

  // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      mis_q     <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      mis_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      mis_q     <= mis_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      mis_out_q <= mis_out_d;
    end
  end

  // NOTE: the storage array has no reset; mem_we is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_d] <= wdata_d;
  end

  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = mis_out_q;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_mips_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] addr, wr_data, rd_data;
  logic        ready, busy, misaligned;

  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, busy1, misaligned1;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .ready        (ready),
    .busy         (busy)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misaligned   (misaligned)
`endif
  );

  mips_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (rd1),
    .mem_write_en (wr1),
    .addr         (addr1),
    .wr_data      (wdata1),
    .rd_data      (rdata1),
    .ready        (ready1),
    .busy         (busy1)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misaligned   (misaligned1)
`endif
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign misaligned  = 1'b0;
  assign misaligned1 = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          due;
    bit          mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [int];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          resp_cnt = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Ready/busy are predicted every cycle from the head of the scoreboard.
  always @(negedge clk) begin : monitor
    bit exp_rdy, exp_busy;
    if (chk_en) begin
      exp_rdy  = (sb_q.size() != 0) && (cyc == sb_q[0].due);
      exp_busy = (sb_q.size() != 0) && (cyc > sb_q[0].acc);
      check("ready", 32'(ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(exp_busy));
`ifdef DMEM_ALIGN_CHECK_EN
      check("misaligned", 32'(misaligned), 32'(exp_rdy && sb_q[0].mis));
`endif
      if (ready && sb_q.size() != 0) begin
        check("rd_data", rd_data, sb_q[0].data);
        void'(sb_q.pop_front());
        resp_cnt++;
      end
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input bit hold);
    exp_t e;
    int   idx;
    int   start;
    bit   done;
    bit   mis;
    idx = int'(a[11:2]);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    e.data = mis ? 32'h0 : (model.exists(idx) ? model[idx] : 32'hx);
    if (wr && !mis) model[idx] = d;
    e.acc = cyc;
    e.due = cyc + LAT;
    e.mis = mis;
    mem_read_en  = rd;
    mem_write_en = wr;
    addr         = a;
    wr_data      = d;
    sb_q.push_back(e);
    start = resp_cnt;
    @(negedge clk);
    if (!hold) begin
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      addr         = $urandom;
      wr_data      = $urandom;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt != start) done = 1'b1;
    end
    check("response_timeout", 32'(done), 32'd1);
    if (!done) sb_q.delete();
    @(negedge clk);
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; addr = '0; wr_data = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    chk_en = 1'b1;

    // Write then read with enables dropped after accept.
    req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Enables held through RESP, back-to-back write then read.
    req(1'b0, 1'b1, 32'h14, 32'h1234_5678, 1'b1);
    req(1'b1, 1'b0, 32'h14, 32'h0, 1'b1);

    // Index wraps modulo DEPTH.
    req(1'b0, 1'b1, 32'h1000, 32'h0000_00A5, 1'b0);
    req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Both enables: write wins, old word returned.
    req(1'b0, 1'b1, 32'h20, 32'h3, 1'b0);
    req(1'b1, 1'b1, 32'h20, 32'h5, 1'b0);
    req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    req(1'b0, 1'b1, 32'h10, 32'h9, 1'b0);
    req(1'b0, 1'b1, 32'h12, 32'hFF, 1'b0);
    req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
`else
    req(1'b1, 1'b0, 32'h23, 32'h0, 1'b0);
`endif

    // Reset mid-write abandons the transaction.
    req(1'b0, 1'b1, 32'h30, 32'h11, 1'b0);
    req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    chk_en = 1'b0;
    mem_write_en = 1'b1; addr = 32'h30; wr_data = 32'h77;
    @(negedge clk);
    rst = 1'b1; mem_write_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("rst_no_ready", 32'(ready), 32'd0);
      @(negedge clk);
    end
    chk_en = 1'b1;
    req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // Random traffic over a small pre-written window.
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0);
    for (int i = 0; i < 24; i++) begin
      bit r, w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      req(r, w, 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    end
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk_en = 1'b0;

    // LATENCY=1 instance: ready one cycle after accept.
    wr1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h55;
    @(negedge clk);
    check("lat1_wr_ready", 32'(ready1), 32'd1);
    check("lat1_wr_busy", 32'(busy1), 32'd1);
    wr1 = 1'b0;
    @(negedge clk);
    check("lat1_idle_ready", 32'(ready1), 32'd0);
    check("lat1_idle_busy", 32'(busy1), 32'd0);
    rd1 = 1'b1;
    @(negedge clk);
    check("lat1_rd_ready", 32'(ready1), 32'd1);
    check("lat1_rd_data", rdata1, 32'h55);
    rd1 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
